// File: rtl/keystream_xor_pkg.sv
// rtl/keystream_xor_pkg.sv - shared types and defaults for the keystream XOR stage
package keystream_xor_pkg;

  localparam int DEF_DATA_SIZE    = 8;
  localparam int DEF_NUM_MATRICES = 2;

  typedef logic [DEF_DATA_SIZE-1:0] word_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    STREAM = 2'd2,
    REQ    = 2'd3
  } state_t;

endpackage

// File: rtl/keystream_xor_ct_out_reg.sv
// rtl/keystream_xor_ct_out_reg.sv - one-entry valid/ready output register for ciphertext
module ct_out_reg #(
  parameter int DATA_SIZE = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic [DATA_SIZE-1:0] new_data,
  input  logic                 new_last,
  input  logic                 ready_down,
  output logic                 ready_up,
  output logic                 valid,
  output logic [DATA_SIZE-1:0] data,
  output logic                 last
);

  // Space is available when empty or when the held byte leaves this cycle.
  assign ready_up = !valid || ready_down;

  // Load a new byte, otherwise drop the held one once downstream takes it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid <= 1'b0;
      data  <= '0;
      last  <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= new_data;
      last  <= new_last;
    end else if (ready_down) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/keystream_xor.sv
// rtl/keystream_xor.sv - captures a keystream batch and XORs it onto the plaintext stream
module keystream_xor
  import keystream_xor_pkg::*;
#(
  parameter int DATA_SIZE    = DEF_DATA_SIZE,
  parameter int NUM_MATRICES = DEF_NUM_MATRICES,
  parameter int NO_REG       = 64 * NUM_MATRICES
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ks_full,
  input  logic [DATA_SIZE-1:0] ks_data [0:NO_REG-1],
  output logic                 ks_req,
  input  logic                 pt_valid,
  input  logic [DATA_SIZE-1:0] pt_data,
  input  logic                 pt_last,
  output logic                 pt_ready,
  output logic                 ct_valid,
  output logic [DATA_SIZE-1:0] ct_data,
  output logic                 ct_last,
  input  logic                 ct_ready,
  output logic [31:0]          batch_cnt
);

  localparam int IDX_W = $clog2(NO_REG);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NO_REG - 1);

  state_t                 state;
  state_t                 next_state;
  logic [IDX_W-1:0]       idx;
  logic [DATA_SIZE-1:0]   ks_buf [0:NO_REG-1];
  logic                   ready_up;
  logic                   accept;
  logic                   batch_done;

  ct_out_reg #(
    .DATA_SIZE (DATA_SIZE)
  ) u_ct_out_reg (
    .clk        (clk),
    .rst        (rst),
    .load       (accept),
    .new_data   (pt_data ^ ks_buf[idx]),
    .new_last   (pt_last),
    .ready_down (ct_ready),
    .ready_up   (ready_up),
    .valid      (ct_valid),
    .data       (ct_data),
    .last       (ct_last)
  );

  // Next state and handshake outputs; plaintext only flows in STREAM.
  always_comb begin
    next_state = state;
    pt_ready   = 1'b0;
    ks_req     = 1'b0;
    accept     = 1'b0;
    batch_done = 1'b0;
    unique case (state)
      IDLE: begin
        if (ks_full) next_state = LOAD;
      end
      LOAD: begin
        next_state = STREAM;
      end
      STREAM: begin
        pt_ready   = ready_up;
        accept     = pt_valid && ready_up;
        batch_done = accept && ((idx == IDX_LAST) || pt_last);
        if (batch_done) next_state = REQ;
      end
      REQ: begin
        ks_req     = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= next_state;
  end

  // Byte index into the batch: cleared on load, advanced per accepted byte, never wraps.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx <= '0;
    end else if (state == LOAD) begin
      idx <= '0;
    end else if (accept && (idx != IDX_LAST)) begin
      idx <= idx + 1'b1;
    end
  end

  // Keystream buffer is written only in LOAD, so it stays frozen during STREAM.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NO_REG; i++) ks_buf[i] <= '0;
    end else if (state == LOAD) begin
      for (int i = 0; i < NO_REG; i++) ks_buf[i] <= ks_data[i];
    end
  end

  // Count consumed batches once per request pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)               batch_cnt <= '0;
    else if (state == REQ)  batch_cnt <= batch_cnt + 32'd1;
  end

endmodule

// File: doc/keystream_xor.md
# keystream_xor

Downstream consumer of the concatenator. Captures one full keystream batch of NO_REG bytes when the concatenator reports full, then XORs it byte-by-byte against a valid/ready plaintext stream to produce the ciphertext stream. Pulses a request back to the keystream path when the batch is exhausted or the message ends. This forms the final ChaCha20 encrypt stage ahead of Poly1305.

## Interface

Parameters:
- DATA_SIZE, 8, byte width of keystream and plaintext lanes
- NUM_MATRICES, 2, ChaCha blocks per keystream batch
- NO_REG, 64*NUM_MATRICES, bytes per batch

Ports:
- clk  in  1  single clock; all state on rising edge
- rst  in  1  reset; asynchronous, active-low; all registers cleared while low
- ks_full  in  1  level; concatenator batch valid
- ks_data  in  DATA_SIZE x [0:NO_REG-1]  keystream bytes; index 0 is the first byte used
- ks_req  out  1  one-cycle pulse; batch consumed, concatenator may clear and refill
- pt_valid  in  1  plaintext byte valid
- pt_data  in  DATA_SIZE  plaintext byte
- pt_last  in  1  final byte of message, qualified by pt_valid
- pt_ready  out  1  plaintext accepted when pt_valid && pt_ready
- ct_valid  out  1  ciphertext byte valid
- ct_data  out  DATA_SIZE  pt_data XOR keystream byte
- ct_last  out  1  mirrors pt_last of the same byte
- ct_ready  in  1  downstream accepts when ct_valid && ct_ready
- batch_cnt  out  32  batches consumed since reset; wraps modulo 2^32

## Operation

- FSM states: IDLE, LOAD, STREAM, REQ.
- IDLE transitions to LOAD when ks_full=1.
- LOAD copies ks_data into the local buffer in one cycle and clears idx to 0. It then moves to STREAM.
- In STREAM, pt_ready = !ct_valid || ct_ready. Acceptance follows a one-entry output register rule.
- On each accepted byte:
  - Register ct_data = pt_data ^ buf[idx], ct_last = pt_last, ct_valid = 1.
  - Increment idx.
- STREAM transitions to REQ when the accepted byte has idx==NO_REG-1 or pt_last=1. Unused keystream is discarded on pt_last; a new message always starts on a fresh batch.
- The byte at idx==NO_REG-1 that also carries pt_last produces a single transition and a single ks_req.
- REQ drives ks_req=1 for exactly one cycle, increments batch_cnt, then returns to IDLE.
- pt_ready=0 in IDLE, LOAD and REQ.
- ct_valid clears on ct_ready when no new byte is accepted in the same cycle. The output register keeps draining in every state.
- ks_full and ks_data are ignored outside IDLE. The buffer is stable for the whole STREAM phase.
- idx width is $clog2(NO_REG). idx never wraps in-batch; it is reset in LOAD.

## Timing

- Reset values: ks_req=0, pt_ready=0, ct_valid=0, ct_data=0, ct_last=0, batch_cnt=0. State is IDLE, idx=0, buffer all zeros.
- ks_full high at edge N puts the FSM in LOAD. The buffer is captured at edge N+1. pt_ready can assert in cycle N+1 (after edge N+1).
- Latency is 1 cycle: a byte accepted at edge K appears on ct_data after edge K.
- Full throughput is 1 byte/cycle with ct_ready held high.
- The batch's final byte accepted at edge K gives ks_req high in cycle K..K+1. The next LOAD is possible one cycle after ks_req deasserts, with ks_full high at that point.
- A stalled ct_ready holds ct_* stable; pt_ready=0 while ct_valid && !ct_ready.
- Asynchronous reset mid-STREAM drops the in-flight ct byte. The bench must not expect it.

## Structure

- Shared package holds:
  - the state enum {IDLE, LOAD, STREAM, REQ}
  - the DATA_SIZE and NUM_MATRICES defaults
  - the existing word_t typedef
- One sub-module, ct_out_reg: the one-entry valid/ready output register holding ct_data/ct_last. It provides `ready_up = !valid || ready_down`.
- Top-level logic is the FSM, idx counter, keystream buffer and batch_cnt.

## Test plan

- ks_data[i]=i, ks_full=1, 128 plaintext bytes 0xFF with ct_ready=1 -> ct_data[i]=~i, one ks_req after the 128th byte, batch_cnt=1.
- 10-byte message with pt_last on byte 9 -> 10 ct bytes, ct_last only on byte 9, ks_req once, the next message uses a newly loaded batch starting at ks_data[0].
- pt_last on byte index 127 -> exactly one ks_req pulse, batch_cnt increments by 1.
- Random ct_ready deassertion (50%) over 256 bytes, two batches -> no lost or duplicated bytes, ct stable while stalled, ct stream equals the golden XOR.
- ks_data changes while in STREAM -> output uses the captured values only.
- rst low mid-batch at byte 40 -> all outputs at reset values, the FSM waits for ks_full, and the next byte uses ks_data[0].
